// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the miniMIPS boot/run controller.
package prog_loader_pkg;

  localparam int IW_DEF  = 9;
  localparam int AW_DEF  = 8;
  localparam int MAX_LEN = 2 ** AW_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_REPORT
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, starts the core, and times the run.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IW           = IW_DEF,
  parameter int AW           = AW_DEF,
  parameter int CNT_W        = 16,
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT      = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic [AW:0]      load_len,
  input  logic             in_valid,
  input  logic [IW-1:0]    in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [AW-1:0]    imem_addr,
  output logic [IW-1:0]    imem_wdata,
  output logic             cpu_start,
  input  logic             cpu_done,
  output logic             busy,
  output logic             run_done,
  output logic             timed_out,
  output logic             err_len,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int          SCW     = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW:0]       remaining_q, remaining_d;
  logic [SCW-1:0]    start_cnt_q, start_cnt_d;
  logic              imem_we_q, imem_we_d;
  logic [AW-1:0]     imem_addr_q, imem_addr_d;
  logic [IW-1:0]     imem_wdata_q, imem_wdata_d;
  logic              cpu_start_q, cpu_start_d;
  logic              run_done_q, run_done_d;
  logic              timed_out_q, timed_out_d;
  logic              err_len_q, err_len_d;
  logic              cnt_clr, cnt_en;
  logic              len_ok;
  logic              timeout_hit;

  assign len_ok      = (load_len != '0) && (load_len <= LEN_MAX);
  // Reaching TIMEOUT on this increment ends the run, so the abort happens after exactly TIMEOUT RUN cycles.
  assign timeout_hit = (TIMEOUT != 0) && (cycle_count == CNT_W'(TIMEOUT - 1));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    start_cnt_d  = start_cnt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_start_d  = 1'b0;
    run_done_d   = 1'b0;
    timed_out_d  = timed_out_q;
    err_len_d    = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          if (len_ok) begin
            state_d     = ST_LOAD;
            addr_d      = '0;
            remaining_d = load_len;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = addr_q;
          imem_wdata_d = in_data;
          addr_d       = addr_q + AW'(1);
          remaining_d  = remaining_q - (AW + 1)'(1);
          if (remaining_q == (AW + 1)'(1)) begin
            state_d     = ST_START;
            cpu_start_d = 1'b1;
            start_cnt_d = SCW'(START_CYCLES - 1);
          end
        end
      end
      ST_START: begin
        cnt_clr     = 1'b1;
        timed_out_d = 1'b0;
        if (start_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          start_cnt_d = start_cnt_q - SCW'(1);
          cpu_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (cpu_done) begin
          state_d     = ST_REPORT;
          run_done_d  = 1'b1;
          timed_out_d = 1'b0;
        end else begin
          cnt_en = 1'b1;
          if (timeout_hit) begin
            state_d     = ST_REPORT;
            run_done_d  = 1'b1;
            timed_out_d = 1'b1;
          end
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      start_cnt_q  <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_start_q  <= 1'b0;
      run_done_q   <= 1'b0;
      timed_out_q  <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      start_cnt_q  <= start_cnt_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_start_q  <= cpu_start_d;
      run_done_q   <= run_done_d;
      timed_out_q  <= timed_out_d;
      err_len_q    <= err_len_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_run_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .count_o(cycle_count)
  );

  assign in_ready   = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_IDLE);
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_start  = cpu_start_q;
  assign run_done   = run_done_q;
  assign timed_out  = timed_out_q;
  assign err_len    = err_len_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of load/run scenarios plus error and reset sequences.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_req;
  logic [8:0]  load_len;
  logic        in_valid;
  logic [8:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [8:0]  imem_wdata;
  logic        cpu_start;
  logic        cpu_done;
  logic        busy;
  logic        run_done;
  logic        timed_out;
  logic        err_len;
  logic [15:0] cycle_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] wr_addr_q[$];
  logic [8:0] wr_data_q[$];
  logic [8:0] prog[6];

  typedef struct {
    int len;
    bit gap;
    int done_after;
    bit poke;
    int exp_count;
    bit exp_to;
  } scen_t;

  scen_t tbl[5];

  prog_loader #(
    .IW(9), .AW(8), .CNT_W(16), .START_CYCLES(1), .TIMEOUT(4096)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_start  (cpu_start),
    .cpu_done   (cpu_done),
    .busy       (busy),
    .run_done   (run_done),
    .timed_out  (timed_out),
    .err_len    (err_len),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] word_of(input int i);
    if (i < 6) return prog[i];
    return 9'((i * 37 + 11) % 512);
  endfunction

  function automatic logic [63:0] all_outs();
    return {24'd0, busy, in_ready, imem_we, imem_addr, imem_wdata, cpu_start,
            run_done, timed_out, err_len, cycle_count};
  endfunction

  task automatic feed(input int n, input bit gap, output bit ok);
    int sent = 0;
    int cyc  = 0;
    bit hs;
    while (sent < n && cyc < 2000) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      in_data  = word_of(sent);
      hs       = in_valid && in_ready;
      step();
      if (hs) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    ok = (sent == n);
  endtask

  task automatic start_load(input int len);
    load_req = 1'b1;
    load_len = 9'(len);
    step();
    load_req = 1'b0;
    load_len = '0;
  endtask

  task automatic run_scenario(input scen_t s);
    bit ok;
    int run_cyc;
    int errs;
    wr_addr_q.delete();
    wr_data_q.delete();
    start_load(s.len);
    check("busy_load", busy, 1);
    feed(s.len, s.gap, ok);
    check("feed_ok", ok, 1);
    check("in_ready_drop", in_ready, 0);
    check("last_we", imem_we, 1);
    check("last_addr", imem_addr, 64'(s.len - 1));
    check("start_hi", cpu_start, 1);
    step();
    check("start_lo", cpu_start, 0);
    run_cyc = 0;
    while (!run_done && run_cyc < 6000) begin
      cpu_done = (s.done_after >= 0) && (run_cyc >= s.done_after);
      if (s.poke && run_cyc == 5) begin
        load_req = 1'b1;
        load_len = 9'd3;
      end else begin
        load_req = 1'b0;
      end
      step();
      run_cyc++;
    end
    load_req = 1'b0;
    cpu_done = 1'b0;
    check("run_done", run_done, 1);
    check("cycle_count", cycle_count, 64'(s.exp_count));
    check("timed_out", timed_out, 64'(s.exp_to));
    check("err_quiet", err_len, 0);
    check("wr_len", wr_addr_q.size(), 64'(s.len));
    errs = 0;
    for (int i = 0; i < wr_addr_q.size() && i < s.len; i++) begin
      if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== word_of(i)) errs++;
    end
    check("wr_seq", errs, 0);
    step();
    check("idle_busy", busy, 0);
    check("pulse_once", run_done, 0);
    check("to_hold", timed_out, 64'(s.exp_to));
  endtask

  initial begin
    bit ok;
    prog = '{9'b010100000, 9'b000101000, 9'b001111000,
             9'b010000000, 9'b101110000, 9'b101110100};
    //        len  gap done poke count  to
    tbl[0] = '{6,   0,  20,  0,  20,   0};
    tbl[1] = '{6,   1,  20,  0,  20,   0};
    tbl[2] = '{256, 0,  0,   0,  0,    0};
    tbl[3] = '{6,   1,  3,   1,  3,    0};
    tbl[4] = '{6,   0,  -1,  1,  4096, 1};

    rst_n    = 1'b0;
    load_req = 1'b0;
    load_len = '0;
    in_valid = 1'b0;
    in_data  = '0;
    cpu_done = 1'b0;
    repeat (2) step();
    check("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    step();

    // Illegal lengths: error pulse only, no state change or writes.
    wr_addr_q.delete();
    wr_data_q.delete();
    start_load(0);
    check("err_len0", err_len, 1);
    check("err_busy0", busy, 0);
    step();
    check("err_pulse0", err_len, 0);
    start_load(257);
    check("err_len257", err_len, 1);
    check("err_busy257", busy, 0);
    step();
    check("err_pulse257", err_len, 0);
    check("err_no_wr", wr_addr_q.size(), 0);

    for (int i = 0; i < 5; i++) run_scenario(tbl[i]);

    // Reset mid-LOAD after three words; timed_out is still set from the timeout run.
    start_load(6);
    feed(3, 1'b0, ok);
    check("part_feed", ok, 1);
    check("part_we", imem_we, 1);
    rst_n = 1'b0;
    #1;
    check("rst_load_outs", all_outs(), 0);
    step();
    rst_n = 1'b1;
    step();

    // Reset while cpu_start is high.
    start_load(2);
    feed(2, 1'b0, ok);
    check("start_feed", ok, 1);
    check("start_seen", cpu_start, 1);
    rst_n = 1'b0;
    #1;
    check("rst_start_outs", all_outs(), 0);
    step();
    rst_n = 1'b1;
    step();

    run_scenario(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
